// File: rtl/frac_pwm_mc.sv
// Multi-channel fractional PWM: shared period counter, per-channel first-order
// dither between int and int+1, double-buffered duty loaded at frame boundaries.
module frac_pwm_mc #(
    parameter int WIDTH = 17,
    parameter int FBITS = 3,
    parameter int NCH = 4,
    parameter logic [NCH-1:0] INV_MASK = '0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_enable,
    input  logic [WIDTH-1:0]             i_period,
    input  logic [NCH*(WIDTH+FBITS)-1:0] i_duty_in,
    input  logic [NCH-1:0]               i_duty_wr,
    output logic [NCH-1:0]               o_pwm_out,
    output logic                         o_frame_start,
    output logic [NCH-1:0]               o_upd_ack
);

    localparam int DW = WIDTH + FBITS;

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_periodAct;
    logic             r_running;
    logic             r_frameStart;
    logic [NCH-1:0]   r_pwm;
    logic [NCH-1:0]   r_updAck;
    logic [NCH-1:0]   r_updPend;
    logic [DW-1:0]    r_shadow [NCH];
    logic [FBITS-1:0] r_acc    [NCH];
    logic [WIDTH:0]   r_cmp    [NCH];

    logic             w_run;
    logic             w_boundary;
    logic [DW-1:0]    w_nextActive [NCH];
    logic [FBITS:0]   w_accSum     [NCH];
    logic [WIDTH:0]   w_nextCmp    [NCH];

    // The first enabled cycle after idle is treated as a boundary so the
    // opening frame starts with freshly loaded duty and a cleared accumulator.
    assign w_run      = i_enable & r_running;
    assign w_boundary = i_enable & (~r_running | (r_cnt == r_periodAct));

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_nextActive[i] = i_duty_wr[i] ? i_duty_in[i*DW +: DW] : r_shadow[i];
            w_accSum[i]     = {1'b0, r_acc[i]} + {1'b0, w_nextActive[i][FBITS-1:0]};
            w_nextCmp[i]    = {1'b0, w_nextActive[i][DW-1:FBITS]}
                            + (WIDTH+1)'(w_accSum[i][FBITS]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_periodAct  <= '0;
            r_running    <= 1'b0;
            r_frameStart <= 1'b0;
            r_pwm        <= INV_MASK;
            r_updAck     <= '0;
            r_updPend    <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_shadow[i] <= '0;
                r_acc[i]    <= '0;
                r_cmp[i]    <= '0;
            end
        end else begin
            r_running    <= i_enable;
            r_frameStart <= w_run & (r_cnt == '0);
            r_updAck     <= w_boundary ? (r_updPend | i_duty_wr) : '0;
            r_updPend    <= w_boundary ? '0 : (r_updPend | i_duty_wr);

            if (!i_enable || w_boundary)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if (w_boundary)
                r_periodAct <= i_period;

            // Compare is one bit wider than the counter, so int+carry never
            // wraps and values past the period naturally give 100% duty.
            for (int i = 0; i < NCH; i++) begin
                r_pwm[i] <= (w_run & ({1'b0, r_cnt} < r_cmp[i])) ^ INV_MASK[i];
                if (i_duty_wr[i])
                    r_shadow[i] <= i_duty_in[i*DW +: DW];
                if (w_boundary) begin
                    r_acc[i] <= w_accSum[i][FBITS-1:0];
                    r_cmp[i] <= w_nextCmp[i];
                end else if (!i_enable) begin
                    r_acc[i] <= '0;
                end
            end
        end
    end

    assign o_pwm_out     = r_pwm;
    assign o_frame_start = r_frameStart;
    assign o_upd_ack     = r_updAck;

endmodule
